// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite constants and helpers for the peripheral register bank and interconnect.
package axi_lite_pkg;

   localparam logic [31:0] AXI_LITE_OOB_DATA = 32'hDEAD_BEEF;
   localparam int          REG_IDX_ID        = 0;
   localparam int          REG_IDX_RW_BASE   = 1;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_data;
      for (int k = 0; k < 4; k++) begin
         if (strb[k]) merged[8*k +: 8] = new_data[8*k +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi_lite_regbank.sv
// AXI-Lite register bank: ID word, NREGS RW control registers with write pulses,
// and a live hardware status word. One outstanding write and one outstanding read.
module axi_lite_regbank
   import axi_lite_pkg::*;
#(
   parameter int          NREGS    = 8,
   parameter logic [31:0] ID_VALUE = 32'h5A5A_0001
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [31:0]           s_awaddr,
   input  logic [2:0]            s_awprot,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   input  logic [31:0]           s_wdata,
   input  logic [3:0]            s_wstrb,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   input  logic [31:0]           s_araddr,
   input  logic [2:0]            s_arprot,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic [31:0]           s_rdata,
   input  logic [31:0]           status_i,
   output logic [NREGS*32-1:0]   regs_o,
   output logic [NREGS-1:0]      wr_pulse_o
);

   localparam logic [9:0] STATUS_IDX = 10'(NREGS + 1);

   logic              aw_held;
   logic [9:0]        addr_q;
   logic              w_held;
   logic [31:0]       data_q;
   logic [3:0]        strb_q;
   logic [31:0]       regs_q [NREGS];
   logic [NREGS-1:0]  wr_pulse_q;

   logic              aw_hs, w_hs, ar_hs, commit;
   logic [9:0]        commit_idx, ar_idx;
   logic [31:0]       commit_data, rd_mux;
   logic [3:0]        commit_strb;
   logic              unused_bits;

   assign unused_bits = ^{s_awprot, s_arprot, s_awaddr[31:12], s_awaddr[1:0],
                          s_araddr[31:12], s_araddr[1:0]};

   assign s_awready = !aw_held && !s_bvalid;
   assign s_wready  = !w_held && !s_bvalid;
   assign s_arready = !s_rvalid;

   assign aw_hs = s_awvalid && s_awready;
   assign w_hs  = s_wvalid && s_wready;
   assign ar_hs = s_arvalid && s_arready;

   // A beat is usable either from its holding register or straight off the bus.
   assign commit      = (aw_held || aw_hs) && (w_held || w_hs) && !s_bvalid;
   assign commit_idx  = aw_held ? addr_q : s_awaddr[11:2];
   assign commit_data = w_held ? data_q : s_wdata;
   assign commit_strb = w_held ? strb_q : s_wstrb;
   assign ar_idx      = s_araddr[11:2];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         aw_held  <= 1'b0;
         addr_q   <= '0;
         w_held   <= 1'b0;
         data_q   <= '0;
         strb_q   <= '0;
         s_bvalid <= 1'b0;
      end else begin
         if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s_bvalid <= 1'b1;
         end else begin
            if (aw_hs) begin
               aw_held <= 1'b1;
               addr_q  <= s_awaddr[11:2];
            end
            if (w_hs) begin
               w_held <= 1'b1;
               data_q <= s_wdata;
               strb_q <= s_wstrb;
            end
            if (s_bvalid && s_bready) s_bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         wr_pulse_q <= '0;
      end else begin
         wr_pulse_q <= '0;
         for (int i = 0; i < NREGS; i++) begin
            if (commit && commit_idx == 10'(REG_IDX_RW_BASE + i)) begin
               regs_q[i]     <= strb_merge(regs_q[i], commit_data, commit_strb);
               wr_pulse_q[i] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_mux = AXI_LITE_OOB_DATA;
      if (ar_idx == 10'(REG_IDX_ID)) begin
         rd_mux = ID_VALUE;
      end else if (ar_idx == STATUS_IDX) begin
         rd_mux = status_i;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (ar_idx == 10'(REG_IDX_RW_BASE + i)) rd_mux = regs_q[i];
         end
      end
   end

   // Read data is captured from pre-commit register values on the AR edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_rvalid <= 1'b0;
         s_rdata  <= '0;
      end else if (ar_hs) begin
         s_rvalid <= 1'b1;
         s_rdata  <= rd_mux;
      end else if (s_rvalid && s_rready) begin
         s_rvalid <= 1'b0;
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_pack
      assign regs_o[32*g +: 32] = regs_q[g];
   end

   assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank against a register-map model.
module tb_axi_lite_regbank;

   localparam int NREGS = 8;
   localparam logic [31:0] ID_VALUE = 32'h5A5A_0001;

   logic                clk = 1'b0;
   logic                resetn;
   logic                s_awvalid, s_awready;
   logic [31:0]         s_awaddr;
   logic [2:0]          s_awprot;
   logic                s_wvalid, s_wready;
   logic [31:0]         s_wdata;
   logic [3:0]          s_wstrb;
   logic                s_bvalid, s_bready;
   logic                s_arvalid, s_arready;
   logic [31:0]         s_araddr;
   logic [2:0]          s_arprot;
   logic                s_rvalid, s_rready;
   logic [31:0]         s_rdata;
   logic [31:0]         status_i;
   logic [NREGS*32-1:0] regs_o;
   logic [NREGS-1:0]    wr_pulse_o;

   int checks = 0;
   int failures = 0;
   logic [31:0] model [NREGS];

   always #5 clk = ~clk;

   axi_lite_regbank #(.NREGS(NREGS), .ID_VALUE(ID_VALUE)) dut (
      .clk(clk), .resetn(resetn),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .status_i(status_i), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
   );

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      int idx;
      idx = int'(addr[11:2]);
      if (idx == 0) return ID_VALUE;
      if (idx >= 1 && idx <= NREGS) return model[idx-1];
      if (idx == NREGS + 1) return status_i;
      return 32'hDEAD_BEEF;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb);
      int idx;
      idx = int'(addr[11:2]);
      if (idx >= 1 && idx <= NREGS) begin
         for (int k = 0; k < 4; k++)
            if (strb[k]) model[idx-1][8*k +: 8] = data[8*k +: 8];
      end
   endfunction

   function automatic logic [NREGS*32-1:0] model_packed();
      logic [NREGS*32-1:0] v;
      for (int i = 0; i < NREGS; i++) v[32*i +: 32] = model[i];
      return v;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NREGS; i++) model[i] = '0;
   endfunction

   // Full write with both channels presented together; returns 0 on timeout.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output bit ok);
      bit aw_done, w_done, hs_aw, hs_w;
      aw_done = 0; w_done = 0; ok = 0;
      @(negedge clk);
      s_awvalid = 1; s_awaddr = addr; s_wvalid = 1; s_wdata = data; s_wstrb = strb;
      s_bready = 1;
      for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
         hs_aw = s_awvalid && s_awready;
         hs_w  = s_wvalid && s_wready;
         @(posedge clk);
         @(negedge clk);
         if (hs_aw) begin s_awvalid = 0; aw_done = 1; end
         if (hs_w)  begin s_wvalid = 0;  w_done = 1;  end
      end
      s_awvalid = 0; s_wvalid = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         if (s_bvalid) ok = 1;
         else @(negedge clk);
      end
      if (ok) begin
         model_write(addr, data, strb);
         @(negedge clk);
      end
   endtask

   // Read with rready held high; reports whether rvalid appeared one cycle after AR.
   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output bit ok);
      ok = 0; data = '0;
      @(negedge clk);
      s_arvalid = 1; s_araddr = addr; s_rready = 1;
      for (int n = 0; n < 50 && !s_arready; n++) @(negedge clk);
      @(negedge clk);
      s_arvalid = 0;
      if (s_rvalid) begin ok = 1; data = s_rdata; end
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 0;
      #12;
      checks++;
      if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b00111) begin
         failures++;
         $display("FAIL reset_flags got %b exp 00111", {s_bvalid, s_rvalid, s_awready, s_wready, s_arready});
      end
      checks++;
      if (regs_o !== '0 || wr_pulse_o !== '0 || s_rdata !== '0) begin
         failures++;
         $display("FAIL reset_data regs=%h pulse=%h rdata=%h exp zero", regs_o, wr_pulse_o, s_rdata);
      end
      @(negedge clk);
      resetn = 1;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_read_id_status();
      logic [31:0] d; bit ok;
      axi_read(32'h0000_0000, d, ok);
      checks++;
      if (!ok || d !== 32'h5A5A_0001) begin
         failures++; $display("FAIL read_id ok=%0d got %h exp 5a5a0001", ok, d);
      end
      status_i = $urandom;
      axi_read(32'h0000_0024, d, ok);
      checks++;
      if (!ok || d !== status_i) begin
         failures++; $display("FAIL read_status ok=%0d got %h exp %h", ok, d, status_i);
      end
   endtask

   task automatic test_write_same_cycle();
      @(negedge clk);
      s_awvalid = 1; s_awaddr = 32'h004; s_wvalid = 1; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
      s_bready = 1;
      @(negedge clk);
      s_awvalid = 0; s_wvalid = 0;
      model_write(32'h004, 32'h1234_5678, 4'hF);
      checks++;
      if (s_bvalid !== 1'b1 || regs_o[31:0] !== 32'h1234_5678 || wr_pulse_o !== 8'h01) begin
         failures++;
         $display("FAIL same_cycle_write bvalid=%b reg0=%h pulse=%h exp 1 12345678 01",
                  s_bvalid, regs_o[31:0], wr_pulse_o);
      end
      @(negedge clk);
      checks++;
      if (wr_pulse_o !== 8'h00 || s_bvalid !== 1'b0) begin
         failures++; $display("FAIL pulse_one_cycle pulse=%h bvalid=%b exp 00 0", wr_pulse_o, s_bvalid);
      end
   endtask

   task automatic test_w_before_aw();
      bit ok;
      axi_write(32'h008, 32'h1122_3344, 4'hF, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL w_first_setup timeout got 0 exp 1"); end
      @(negedge clk);
      s_wvalid = 1; s_wdata = 32'hAABB_CCDD; s_wstrb = 4'b0101;
      @(negedge clk);
      s_wvalid = 0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (s_wready !== 1'b0 || s_awready !== 1'b1 || s_bvalid !== 1'b0 || regs_o[63:32] !== 32'h1122_3344) begin
         failures++;
         $display("FAIL w_held wready=%b awready=%b bvalid=%b reg1=%h exp 0 1 0 11223344",
                  s_wready, s_awready, s_bvalid, regs_o[63:32]);
      end
      s_awvalid = 1; s_awaddr = 32'h008;
      @(negedge clk);
      s_awvalid = 0;
      model_write(32'h008, 32'hAABB_CCDD, 4'b0101);
      checks++;
      if (s_bvalid !== 1'b1 || regs_o[63:32] !== 32'h11BB_33DD || wr_pulse_o !== 8'h02) begin
         failures++;
         $display("FAIL w_first_commit bvalid=%b reg1=%h pulse=%h exp 1 11bb33dd 02",
                  s_bvalid, regs_o[63:32], wr_pulse_o);
      end
      @(negedge clk);
   endtask

   task automatic test_b_backpressure();
      bit bad;
      @(negedge clk);
      s_bready = 0;
      s_awvalid = 1; s_awaddr = 32'h00C; s_wvalid = 1; s_wdata = 32'hCAFE_0001; s_wstrb = 4'hF;
      @(negedge clk);
      model_write(32'h00C, 32'hCAFE_0001, 4'hF);
      // second write stays presented while B is stalled
      s_awaddr = 32'h010; s_wdata = 32'hCAFE_0002; s_wstrb = 4'hF;
      bad = 0;
      for (int n = 0; n < 5; n++) begin
         if (s_bvalid !== 1'b1 || s_awready !== 1'b0 || s_wready !== 1'b0) bad = 1;
         @(negedge clk);
      end
      checks++;
      if (bad || regs_o[127:96] !== 32'h0) begin
         failures++; $display("FAIL b_stall held_ok=%0d reg3=%h exp 1 00000000", !bad, regs_o[127:96]);
      end
      s_bready = 1;
      @(negedge clk);
      checks++;
      if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || regs_o[127:96] !== 32'h0) begin
         failures++;
         $display("FAIL b_release bvalid=%b awready=%b reg3=%h exp 0 1 00000000", s_bvalid, s_awready, regs_o[127:96]);
      end
      @(negedge clk);
      s_awvalid = 0; s_wvalid = 0;
      model_write(32'h010, 32'hCAFE_0002, 4'hF);
      checks++;
      if (s_bvalid !== 1'b1 || regs_o !== model_packed()) begin
         failures++; $display("FAIL second_write bvalid=%b regs=%h exp 1 %h", s_bvalid, regs_o, model_packed());
      end
      @(negedge clk);
   endtask

   task automatic test_unmapped();
      bit ok1, ok2, ok3; logic [31:0] d; bit okr;
      axi_write(32'h000, 32'hFFFF_FFFF, 4'hF, ok1);
      axi_write(32'h7F0, 32'hFFFF_FFFF, 4'hF, ok2);
      axi_write(32'h024, 32'hFFFF_FFFF, 4'hF, ok3);
      checks++;
      if (!(ok1 && ok2 && ok3) || regs_o !== model_packed()) begin
         failures++;
         $display("FAIL dropped_writes b=%0d%0d%0d regs=%h exp 111 %h", ok1, ok2, ok3, regs_o, model_packed());
      end
      axi_read(32'h7F0, d, okr);
      checks++;
      if (!okr || d !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL read_unmapped ok=%0d got %h exp deadbeef", okr, d);
      end
   endtask

   task automatic test_random();
      logic [31:0] addr, data, d, exp; logic [3:0] strb; bit ok;
      for (int n = 0; n < 40; n++) begin
         addr = {$urandom_range(0, 1048575), 10'($urandom_range(0, NREGS + 4)), 2'($urandom_range(0, 3))};
         addr[31:12] = 20'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            data = $urandom; strb = 4'($urandom);
            axi_write(addr, data, strb, ok);
            checks++;
            if (!ok || regs_o !== model_packed()) begin
               failures++;
               $display("FAIL rand_write addr=%h ok=%0d regs=%h exp %h", addr, ok, regs_o, model_packed());
            end
         end else begin
            status_i = $urandom;
            exp = model_read(addr);
            axi_read(addr, d, ok);
            checks++;
            if (!ok || d !== exp) begin
               failures++; $display("FAIL rand_read addr=%h ok=%0d got %h exp %h", addr, ok, d, exp);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; bit ok;
      @(negedge clk);
      s_rready = 0; s_arvalid = 1; s_araddr = 32'h004;
      s_wvalid = 1; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
      @(negedge clk);
      s_arvalid = 0; s_wvalid = 0;
      checks++;
      if (s_rvalid !== 1'b1 || s_wready !== 1'b0) begin
         failures++; $display("FAIL pre_reset rvalid=%b wready=%b exp 1 0", s_rvalid, s_wready);
      end
      #2 resetn = 0;
      #1;
      model_clear();
      checks++;
      if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b00111 ||
          regs_o !== '0 || wr_pulse_o !== '0 || s_rdata !== '0) begin
         failures++;
         $display("FAIL async_reset flags=%b regs=%h rdata=%h exp 00111 zero zero",
                  {s_bvalid, s_rvalid, s_awready, s_wready, s_arready}, regs_o, s_rdata);
      end
      @(negedge clk);
      resetn = 1;
      s_rready = 1;
      @(negedge clk);
      axi_write(32'h01C, 32'h0BAD_F00D, 4'hF, ok);
      axi_read(32'h01C, d, ok);
      checks++;
      if (!ok || d !== 32'h0BAD_F00D || regs_o !== model_packed()) begin
         failures++; $display("FAIL post_reset_write ok=%0d got %h exp 0badf00d", ok, d);
      end
   endtask

   initial begin
      s_awvalid = 0; s_awaddr = '0; s_awprot = '0;
      s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_bready = 1;
      s_arvalid = 0; s_araddr = '0; s_arprot = '0; s_rready = 1;
      status_i = '0;
      model_clear();
      test_reset();
      test_read_id_status();
      test_write_same_cycle();
      test_w_before_aw();
      test_b_backpressure();
      test_unmapped();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
